// File: rtl/iobuf_seq.sv
// Break-before-make sequencer for one iobuf pin driver: owns oe/od/dir/din and
// returns the pin level through a two-flop synchronizer.
module iobuf_seq #(
    parameter int unsigned DEADTIME = 4,
    parameter int unsigned SETTLE   = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cmd_valid_i,
    output logic cmd_ready_o,
    input  logic cmd_oe_i,
    input  logic cmd_od_i,
    input  logic cmd_dir_i,
    input  logic cmd_din_i,
    output logic oe_o,
    output logic od_o,
    output logic dir_o,
    output logic din_o,
    input  logic dout_i,
    output logic pin_sync_o,
    output logic busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ARM,
        ST_SETTLE
    } state_t;

    localparam logic [7:0] DEAD_LOAD   = 8'(DEADTIME - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       ready_q;
    logic       oe_q, od_q, dir_q, din_q;
    logic       tgtOe_q, tgtOd_q, tgtDir_q, tgtDin_q;
    logic       sync1_q, sync2_q;
    logic       modeChange_d;

    // Any change to oe, od or dir must go through the Hi-Z turnaround; din alone is safe.
    assign modeChange_d = (cmd_oe_i != oe_q) || (cmd_od_i != od_q) || (cmd_dir_i != dir_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            ready_q  <= 1'b0;
            oe_q     <= 1'b0;
            od_q     <= 1'b0;
            dir_q    <= 1'b0;
            din_q    <= 1'b0;
            tgtOe_q  <= 1'b0;
            tgtOd_q  <= 1'b0;
            tgtDir_q <= 1'b0;
            tgtDin_q <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
        end else begin
            sync1_q <= dout_i;
            sync2_q <= sync1_q;
            case (state_q)
                ST_IDLE: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (cmd_valid_i) begin
                        if (!modeChange_d) begin
                            din_q <= cmd_din_i;
                        end else begin
                            tgtOe_q  <= cmd_oe_i;
                            tgtOd_q  <= cmd_od_i;
                            tgtDir_q <= cmd_dir_i;
                            tgtDin_q <= cmd_din_i;
                            ready_q  <= 1'b0;
                            if (oe_q) begin
                                oe_q    <= 1'b0;
                                cnt_q   <= DEAD_LOAD;
                                state_q <= ST_DRAIN;
                            end else begin
                                od_q    <= cmd_od_i;
                                dir_q   <= cmd_dir_i;
                                din_q   <= cmd_din_i;
                                state_q <= ST_ARM;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == 8'd0) begin
                        od_q    <= tgtOd_q;
                        dir_q   <= tgtDir_q;
                        din_q   <= tgtDin_q;
                        state_q <= ST_ARM;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_ARM: begin
                    oe_q <= tgtOe_q;
                    if (tgtOe_q) begin
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= ST_SETTLE;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign busy_o      = !ready_q;
    assign oe_o        = oe_q;
    assign od_o        = od_q;
    assign dir_o       = dir_q;
    assign din_o       = din_q;
    assign pin_sync_o  = sync2_q;

endmodule

// File: tb/tb_iobuf_seq.sv
// Scoreboard bench for iobuf_seq: stimulus pushes a per-command timeline model,
// an edge monitor compares every cycle of the resulting sequence.
module tb_iobuf_seq;

    localparam int D = 4;
    localparam int S = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic cmd_valid_i = 1'b0;
    logic cmd_oe_i = 1'b0, cmd_od_i = 1'b0, cmd_dir_i = 1'b0, cmd_din_i = 1'b0;
    logic dout_i = 1'b0;
    logic cmd_ready_o, oe_o, od_o, dir_o, din_o, pin_sync_o, busy_o;

    int total = 0;
    int bad = 0;

    // Bits are packed as {oe, od, dir, din}.
    typedef struct {
        int         kind;
        logic [3:0] oldV;
        logic [3:0] tgtV;
        int         lat;
    } expRec_t;

    expRec_t    expQ[$];
    expRec_t    cur;
    logic [3:0] model = 4'b0000;
    logic [3:0] settled = 4'b0000;
    bit         pending = 1'b0;
    int         elapsed = 0;
    logic       dPrev = 1'b0;
    logic       rstPrev = 1'b1;

    iobuf_seq #(.DEADTIME(D), .SETTLE(S)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_oe_i    (cmd_oe_i),
        .cmd_od_i    (cmd_od_i),
        .cmd_dir_i   (cmd_dir_i),
        .cmd_din_i   (cmd_din_i),
        .oe_o        (oe_o),
        .od_o        (od_o),
        .dir_o       (dir_o),
        .din_o       (din_o),
        .dout_i      (dout_i),
        .pin_sync_o  (pin_sync_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) dout_i = 1'($urandom_range(0, 1));

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    // Kind 0 = data only, 1 = turnaround from driving, 2 = reconfigure from Hi-Z.
    function automatic expRec_t makeRec(input logic [3:0] oldV, input logic [3:0] tgtV);
        expRec_t r;
        r.oldV = oldV;
        r.tgtV = tgtV;
        if (tgtV[3:1] == oldV[3:1]) begin
            r.kind = 0;
            r.lat  = 1;
        end else if (oldV[3]) begin
            r.kind = 1;
            r.lat  = D + 2 + (tgtV[3] ? S : 0);
        end else begin
            r.kind = 2;
            r.lat  = 2 + (tgtV[3] ? S : 0);
        end
        return r;
    endfunction

    // Pin controls k edges after the accept edge, counting the accept edge as k=1.
    function automatic logic [3:0] expectAt(input expRec_t r, input int k);
        if (r.kind == 1) begin
            if (k <= D)          return {1'b0, r.oldV[2:0]};
            else if (k == D + 1) return {1'b0, r.tgtV[2:0]};
            else                 return r.tgtV;
        end else if (r.kind == 2) begin
            if (k == 1) return {1'b0, r.tgtV[2:0]};
            else        return r.tgtV;
        end
        return r.tgtV;
    endfunction

    always @(posedge clk_i) begin : monitor
        logic       accNow, rstNow, dNow;
        logic [3:0] prevOut, act;
        accNow  = cmd_valid_i && cmd_ready_o && !rst_i;
        rstNow  = rst_i;
        dNow    = dout_i;
        prevOut = {oe_o, od_o, dir_o, din_o};
        #1;
        act = {oe_o, od_o, dir_o, din_o};
        checkOutput("pin_sync", {3'b000, pin_sync_o}, {3'b000, (rstNow || rstPrev) ? 1'b0 : dPrev});
        checkOutput("busy", {3'b000, busy_o}, {3'b000, !cmd_ready_o});
        if (rstNow) begin
            checkOutput("reset controls", act, 4'b0000);
            checkOutput("reset cmd_ready", {3'b000, cmd_ready_o}, 4'b0000);
            pending = 1'b0;
            settled = 4'b0000;
        end else begin
            if (accNow) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected accept at %0t: got accept, expected none", $time);
                end else begin
                    cur     = expQ.pop_front();
                    pending = 1'b1;
                    elapsed = 0;
                end
            end
            if (pending) begin
                elapsed++;
                checkOutput("pin controls", act, expectAt(cur, elapsed));
                checkOutput("cmd_ready", {3'b000, cmd_ready_o}, {3'b000, elapsed >= cur.lat});
                if (elapsed >= cur.lat) begin
                    pending = 1'b0;
                    settled = cur.tgtV;
                end
            end else begin
                checkOutput("idle controls", act, settled);
                checkOutput("idle cmd_ready", {3'b000, cmd_ready_o}, 4'b0001);
            end
            if (act[2:1] !== prevOut[2:1])
                checkOutput("oe low around od/dir change", {2'b00, prevOut[3], act[3]}, 4'b0000);
        end
        dPrev   = dNow;
        rstPrev = rstNow;
    end

    // Issue one command from a negedge; abortAfter > 0 pulses reset that many cycles after accept.
    task automatic applyStimulus(input logic [3:0] tgt, input int abortAfter);
        int guard;
        {cmd_oe_i, cmd_od_i, cmd_dir_i, cmd_din_i} = tgt;
        cmd_valid_i = 1'b1;
        guard = 0;
        while (cmd_ready_o !== 1'b1 && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 100) begin
            total++;
            bad++;
            $display("[TB] FAIL accept timeout at %0t: got cmd_ready=%b, expected 1", $time, cmd_ready_o);
            cmd_valid_i = 1'b0;
            return;
        end
        expQ.push_back(makeRec(model, tgt));
        model = tgt;
        @(negedge clk_i);
        if (abortAfter > 0) begin
            cmd_valid_i = 1'b0;
            repeat (abortAfter) @(negedge clk_i);
            rst_i = 1'b1;
            model = 4'b0000;
            @(negedge clk_i);
            rst_i = 1'b0;
            return;
        end
        guard = 0;
        while (cmd_ready_o !== 1'b1 && guard < 100) begin
            {cmd_oe_i, cmd_od_i, cmd_dir_i, cmd_din_i} = 4'($urandom);
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 100) begin
            total++;
            bad++;
            $display("[TB] FAIL completion timeout at %0t: got cmd_ready=%b, expected 1", $time, cmd_ready_o);
        end
        cmd_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        applyStimulus(4'b0001, 0);
        applyStimulus(4'b1010, 0);
        applyStimulus(4'b1000, 0);
        applyStimulus(4'b0101, 0);
        applyStimulus(4'b0100, 0);
        applyStimulus(4'b0101, 0);
        applyStimulus(4'b0100, 0);
        repeat (60) begin
            applyStimulus(4'($urandom), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end
        applyStimulus(4'b1000, 0);
        applyStimulus(4'b1010, 2);
        applyStimulus(4'b1010, 0);
        applyStimulus(4'b0011, 0);
        repeat (5) @(negedge clk_i);
        checkOutput("scoreboard drained", {3'b000, pending || (expQ.size() != 0)}, 4'b0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog at %0t: got no finish, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
